// File: rtl/ps2mouse_dev.sv
// PS/2 mouse device emulator: drives the PS/2 clock, sends movement packets
// and command responses, receives host commands and answers the standard
// mouse init sequence. Both pins are open collector (driven 0 or released).
module ps2mouse_dev #(
    parameter int HALF    = 2000,
    parameter int INHIBIT = 4000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2mclk,
    inout  wire        ps2mdat,
    input  logic [8:0] dx,
    input  logic [8:0] dy,
    input  logic [2:0] btn,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    output logic [7:0] cmd,
    output logic       cmd_strobe,
    output logic       reporting,
    output logic [7:0] rate,
    output logic       busy
);

    localparam logic [15:0] HALF_END    = 16'(HALF - 1);
    localparam logic [15:0] SAMPLE_AT   = 16'(HALF / 2);
    localparam logic [15:0] INHIBIT_C   = 16'(INHIBIT);
    // The synchronized clock lags our own release by two cycles; ignore the
    // start of phase A so our previous low phase is not mistaken for the host.
    localparam logic [15:0] SYNC_SETTLE = 16'd3;
    localparam logic [7:0]  RATE_DFLT   = 8'd100;

    typedef enum logic [2:0] {ST_IDLE, ST_TX, ST_INHIB, ST_RX, ST_ACK} state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [3:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [9:0]  rx_q, rx_d;
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];
    logic [1:0]  head_q, head_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic        clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic [7:0]  cmd_q, cmd_d, rate_q, rate_d;
    logic        cmd_strobe_q, cmd_strobe_d, pkt_ready_q, pkt_ready_d;
    logic        reporting_q, reporting_d, rate_pending_q, rate_pending_d;
    logic        busy_q, busy_d;
    logic        bus_idle_s, phase_end_s, rx_ok_s;
    logic [10:0] tx_frame_s;

    assign ps2mclk    = clk_oe_q ? 1'b0 : 1'bz;
    assign ps2mdat    = dat_oe_q ? 1'b0 : 1'bz;
    assign pkt_ready  = pkt_ready_q;
    assign cmd        = cmd_q;
    assign cmd_strobe = cmd_strobe_q;
    assign reporting  = reporting_q;
    assign rate       = rate_q;
    assign busy       = busy_q;

    // Two-flop synchronizers on both bus lines (idle level is high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2mclk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2mdat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Next-state, queue, command decode and registered pin/output values.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        bit_d          = bit_q;
        phase_d        = phase_q;
        rx_d           = rx_q;
        fifo_d         = fifo_q;
        head_d         = head_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        rate_d         = rate_q;
        reporting_d    = reporting_q;
        rate_pending_d = rate_pending_q;
        cmd_strobe_d   = 1'b0;
        pkt_ready_d    = 1'b0;
        clk_oe_d       = 1'b0;
        dat_oe_d       = 1'b0;
        bus_idle_s     = clk_sync_q & dat_sync_q;
        phase_end_s    = (tmr_q == HALF_END);
        rx_ok_s        = (rx_q[8] == odd_parity(rx_q[7:0])) & rx_q[9];
        tx_frame_s     = {1'b1, odd_parity(fifo_q[head_q]), fifo_q[head_q], 1'b0};

        case (state_q)
            ST_IDLE: begin
                if (!clk_sync_q) begin
                    state_d = ST_INHIB;
                    tmr_d   = 16'd1;
                end else if (cnt_q != 3'd0) begin
                    if (!bus_idle_s) begin
                        tmr_d = 16'd0;
                    end else if (phase_end_s) begin
                        state_d = ST_TX;
                        tmr_d   = 16'd0;
                        bit_d   = 4'd0;
                        phase_d = 1'b0;
                    end else begin
                        tmr_d = tmr_q + 16'd1;
                    end
                end else if (reporting_q && pkt_valid) begin
                    // Packets load only into an empty queue, so they never overflow it.
                    fifo_d[0]   = {2'b00, dy[8], dx[8], 1'b1, btn};
                    fifo_d[1]   = dx[7:0];
                    fifo_d[2]   = dy[7:0];
                    head_d      = 2'd0;
                    cnt_d       = 3'd3;
                    pkt_ready_d = 1'b1;
                    tmr_d       = 16'd0;
                end else begin
                    tmr_d = 16'd0;
                end
            end
            ST_TX: begin
                if (!phase_q && (bit_q != 4'd10) && (tmr_q >= SYNC_SETTLE) && !clk_sync_q) begin
                    // Host inhibit: abandon the frame, byte stays at the queue head.
                    state_d = ST_INHIB;
                    tmr_d   = 16'd1;
                end else if (phase_end_s) begin
                    tmr_d = 16'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd10) begin
                        state_d = ST_IDLE;
                        phase_d = 1'b0;
                        head_d  = head_q + 2'd1;
                        cnt_d   = cnt_q - 3'd1;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_INHIB: begin
                if (clk_sync_q) begin
                    tmr_d   = 16'd0;
                    bit_d   = 4'd0;
                    phase_d = 1'b0;
                    if ((tmr_q >= INHIBIT_C) && !dat_sync_q) begin
                        state_d = ST_RX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_q != 16'hFFFF) begin
                    tmr_d = tmr_q + 16'd1;
                end else begin
                    tmr_d = tmr_q;
                end
            end
            ST_RX: begin
                // phase 0 = clock driven low, phase 1 = clock released.
                if (phase_q && (tmr_q == SAMPLE_AT)) begin
                    rx_d[bit_q] = dat_sync_q;
                end else begin
                    rx_d = rx_q;
                end
                if (phase_end_s) begin
                    tmr_d = 16'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd9) begin
                        state_d = ST_ACK;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_ACK: begin
                if (phase_end_s) begin
                    tmr_d = 16'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Frame complete: every outcome replaces whatever was queued.
                        state_d = ST_IDLE;
                        phase_d = 1'b0;
                        head_d  = 2'd0;
                        cnt_d   = 3'd1;
                        fifo_d[0] = 8'hFA;
                        if (!rx_ok_s) begin
                            fifo_d[0] = 8'hFE;
                        end else begin
                            cmd_d        = rx_q[7:0];
                            cmd_strobe_d = 1'b1;
                            if (rate_pending_q) begin
                                rate_d         = rx_q[7:0];
                                rate_pending_d = 1'b0;
                            end else begin
                                case (rx_q[7:0])
                                    8'hFF: begin
                                        reporting_d = 1'b0;
                                        rate_d      = RATE_DFLT;
                                        fifo_d[1]   = 8'hAA;
                                        fifo_d[2]   = 8'h00;
                                        cnt_d       = 3'd3;
                                    end
                                    8'hF6: begin
                                        reporting_d = 1'b0;
                                        rate_d      = RATE_DFLT;
                                    end
                                    8'hF2: begin
                                        fifo_d[1] = 8'h00;
                                        cnt_d     = 3'd2;
                                    end
                                    8'hF3:   rate_pending_d = 1'b1;
                                    8'hF4:   reporting_d    = 1'b1;
                                    8'hF5:   reporting_d    = 1'b0;
                                    default: fifo_d[0]      = 8'hFE;
                                endcase
                            end
                        end
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = 16'd0;
            end
        endcase

        case (state_d)
            ST_TX: begin
                clk_oe_d = phase_d;
                dat_oe_d = ~tx_frame_s[bit_d];
            end
            ST_RX: begin
                clk_oe_d = ~phase_d;
                dat_oe_d = 1'b0;
            end
            ST_ACK: begin
                clk_oe_d = ~phase_d;
                dat_oe_d = 1'b1;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_TX) || (state_d == ST_RX) || (state_d == ST_ACK) ||
                 (cnt_d != 3'd0);
    end

    // State, queue and output registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            tmr_q          <= 16'd0;
            bit_q          <= 4'd0;
            phase_q        <= 1'b0;
            rx_q           <= 10'd0;
            fifo_q         <= '{default: 8'h00};
            head_q         <= 2'd0;
            cnt_q          <= 3'd0;
            clk_oe_q       <= 1'b0;
            dat_oe_q       <= 1'b0;
            cmd_q          <= 8'h00;
            rate_q         <= RATE_DFLT;
            reporting_q    <= 1'b0;
            rate_pending_q <= 1'b0;
            cmd_strobe_q   <= 1'b0;
            pkt_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            bit_q          <= bit_d;
            phase_q        <= phase_d;
            rx_q           <= rx_d;
            fifo_q         <= fifo_d;
            head_q         <= head_d;
            cnt_q          <= cnt_d;
            clk_oe_q       <= clk_oe_d;
            dat_oe_q       <= dat_oe_d;
            cmd_q          <= cmd_d;
            rate_q         <= rate_d;
            reporting_q    <= reporting_d;
            rate_pending_q <= rate_pending_d;
            cmd_strobe_q   <= cmd_strobe_d;
            pkt_ready_q    <= pkt_ready_d;
            busy_q         <= busy_d;
        end
    end

endmodule

// File: tb/tb_ps2mouse_dev.sv
// Directed bench for ps2mouse_dev: a behavioural PS/2 host sends commands,
// receives response/packet bytes and checks values, framing and outputs.
module tb_ps2mouse_dev;

    localparam int H   = 20;
    localparam int INH = 60;
    localparam int TMO = 40 * H;

    logic       clk = 1'b0;
    logic       reset;
    wire        ps2mclk;
    wire        ps2mdat;
    logic [8:0] dx, dy;
    logic [2:0] btn;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [7:0] cmd;
    logic       cmd_strobe;
    logic       reporting;
    logic [7:0] rate;
    logic       busy;

    logic hclk_lo, hdat_lo;
    int   n_vec, n_err, n_strobe, n_rdy, rdy_run, rdy_max;
    bit   dead;

    assign ps2mclk = hclk_lo ? 1'b0 : 1'bz;
    assign ps2mdat = hdat_lo ? 1'b0 : 1'bz;
    pullup (ps2mclk);
    pullup (ps2mdat);

    always #5 clk = ~clk;

    ps2mouse_dev #(.HALF(H), .INHIBIT(INH)) dut (
        .clk(clk), .reset(reset), .ps2mclk(ps2mclk), .ps2mdat(ps2mdat),
        .dx(dx), .dy(dy), .btn(btn), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .cmd(cmd), .cmd_strobe(cmd_strobe), .reporting(reporting), .rate(rate), .busy(busy)
    );

    // Count strobe and pkt_ready pulses, tracking the widest pkt_ready pulse.
    always @(negedge clk) begin
        if (cmd_strobe) n_strobe++;
        if (pkt_ready) begin
            n_rdy++;
            rdy_run++;
            if (rdy_run > rdy_max) rdy_max = rdy_run;
        end else begin
            rdy_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_lvl(input logic lvl);
        int n;
        n = 0;
        while (!dead && (ps2mclk !== lvl) && (n < TMO)) begin
            @(negedge clk);
            n++;
        end
        if (!dead && (ps2mclk !== lvl)) begin
            chk("clk_wait_timeout", 32'(ps2mclk), 32'(lvl));
            dead = 1'b1;
        end
    endtask

    task automatic host_send(input logic [7:0] b, input logic bad_par);
        logic [9:0] bits;
        bits = {1'b1, (~(^b)) ^ bad_par, b};
        @(negedge clk);
        hclk_lo = 1'b1;
        repeat (INH + 20) @(negedge clk);
        hdat_lo = 1'b1;
        repeat (5) @(negedge clk);
        hclk_lo = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            wait_lvl(1'b0);
            hdat_lo = ~bits[i];
            wait_lvl(1'b1);
        end
        wait_lvl(1'b0);
        repeat (3) @(negedge clk);
        chk($sformatf("ack_%02h", b), 32'(ps2mdat), 32'd0);
        wait_lvl(1'b1);
    endtask

    // Receive one device frame; check start, stop, odd parity and the byte.
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [10:0] fr;
        fr = '0;
        for (int i = 0; i < 11; i++) begin
            wait_lvl(1'b0);
            fr[i] = ps2mdat;
            wait_lvl(1'b1);
        end
        chk(tag, 32'({fr[0], fr[10], ^fr[9:1], fr[8:1]}), 32'({1'b0, 1'b1, 1'b1, exp}));
    endtask

    task automatic offer_pkt(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
        int n;
        dx = x;
        dy = y;
        btn = b;
        pkt_valid = 1'b1;
        n = 0;
        while ((pkt_ready !== 1'b1) && (n < TMO)) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_ready_seen", 32'(pkt_ready), 32'd1);
        pkt_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_strobe = 0; n_rdy = 0; rdy_run = 0; rdy_max = 0;
        dead = 1'b0; reset = 1'b0; hclk_lo = 1'b0; hdat_lo = 1'b0;
        dx = 9'd0; dy = 9'd0; btn = 3'd0; pkt_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rate", 32'(rate), 32'd100);
        chk("rst_reporting", 32'(reporting), 32'd0);
        chk("rst_cmd", 32'({cmd_strobe, pkt_ready, cmd}), 32'd0);
        chk("rst_pins", 32'({ps2mclk, ps2mdat}), 32'd3);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Reset command: FA, AA, 00.
        host_send(8'hFF, 1'b0);
        expect_byte("ff_r0", 8'hFA);
        expect_byte("ff_r1", 8'hAA);
        expect_byte("ff_r2", 8'h00);
        repeat (5) @(negedge clk);
        chk("ff_cmd", 32'(cmd), 32'hFF);
        chk("ff_strobes", 32'(n_strobe), 32'd1);
        chk("ff_rate_rep", 32'({reporting, rate}), 32'd100);

        // Set sample rate to 200.
        host_send(8'hF3, 1'b0);
        expect_byte("f3_r0", 8'hFA);
        host_send(8'hC8, 1'b0);
        expect_byte("c8_r0", 8'hFA);
        repeat (5) @(negedge clk);
        chk("rate_200", 32'(rate), 32'd200);
        chk("cmd_c8", 32'(cmd), 32'hC8);
        chk("rate_strobes", 32'(n_strobe), 32'd3);

        // Enable reporting, packet 1 with a host inhibit during byte1.
        host_send(8'hF4, 1'b0);
        expect_byte("f4_r0", 8'hFA);
        chk("f4_reporting", 32'(reporting), 32'd1);
        offer_pkt(9'h1FE, 9'h000, 3'b001);
        expect_byte("pkt1_b0", 8'h19);
        for (int i = 0; i < 4; i++) begin
            wait_lvl(1'b0);
            wait_lvl(1'b1);
        end
        repeat (4) @(negedge clk);
        hclk_lo = 1'b1;
        repeat (INH + 15) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_dat", 32'(ps2mdat), 32'd1);
        hclk_lo = 1'b0;
        @(negedge clk);
        expect_byte("pkt1_b1_resent", 8'hFE);
        expect_byte("pkt1_b2", 8'h00);
        chk("pkt1_rdy_width", 32'(rdy_max), 32'd1);
        chk("pkt1_rdy_count", 32'(n_rdy), 32'd1);

        // Packet 2: dx=+5, dy=-1, middle+right.
        offer_pkt(9'h005, 9'h1FF, 3'b110);
        expect_byte("pkt2_b0", 8'h2E);
        expect_byte("pkt2_b1", 8'h05);
        expect_byte("pkt2_b2", 8'hFF);
        chk("pkt2_rdy_count", 32'(n_rdy), 32'd2);

        // Bad parity: FE, no strobe, rate untouched and no pending rate.
        host_send(8'hF3, 1'b1);
        expect_byte("badpar_r0", 8'hFE);
        repeat (5) @(negedge clk);
        chk("badpar_strobes", 32'(n_strobe), 32'd4);
        chk("badpar_rate_cmd", 32'({rate, cmd}), 32'hC8F4);
        host_send(8'hAB, 1'b0);
        expect_byte("unk_r0", 8'hFE);
        repeat (5) @(negedge clk);
        chk("unk_rate_cmd", 32'({rate, cmd}), 32'hC8AB);

        // Read ID.
        host_send(8'hF2, 1'b0);
        expect_byte("f2_r0", 8'hFA);
        expect_byte("f2_r1", 8'h00);

        // Disable reporting; an offered sample must be ignored.
        host_send(8'hF5, 1'b0);
        expect_byte("f5_r0", 8'hFA);
        dx = 9'h011; dy = 9'h022; btn = 3'b111; pkt_valid = 1'b1;
        repeat (400) @(negedge clk);
        chk("noreport_rdy", 32'(n_rdy), 32'd2);
        chk("noreport_idle", 32'({busy, reporting, ps2mclk, ps2mdat}), 32'b0011);
        pkt_valid = 1'b0;

        // Set defaults, then a new rate and reporting on.
        host_send(8'hF6, 1'b0);
        expect_byte("f6_r0", 8'hFA);
        repeat (5) @(negedge clk);
        chk("f6_rate", 32'(rate), 32'd100);
        host_send(8'hF3, 1'b0);
        expect_byte("f3b_r0", 8'hFA);
        host_send(8'h50, 1'b0);
        expect_byte("r50_r0", 8'hFA);
        host_send(8'hF4, 1'b0);
        expect_byte("f4b_r0", 8'hFA);
        repeat (5) @(negedge clk);
        chk("pre_rst_state", 32'({reporting, rate, cmd}), 32'h150F4);
        chk("pre_rst_strobes", 32'(n_strobe), 32'd11);

        // Reset in the middle of the second F2 response byte.
        host_send(8'hF2, 1'b0);
        expect_byte("f2b_r0", 8'hFA);
        wait_lvl(1'b0);
        chk("midtx_driven", 32'({ps2mclk, ps2mdat}), 32'd0);
        reset = 1'b0;
        #1;
        chk("midtx_rst_release", 32'({ps2mclk, ps2mdat}), 32'd3);
        @(negedge clk);
        chk("midtx_rst_outs", 32'({busy, reporting, cmd_strobe, pkt_ready, rate, cmd}), 32'h06400);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        chk("post_rst_idle", 32'({busy, ps2mclk, ps2mdat}), 32'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2mouse_dev.md
# ps2mouse_dev

PS/2 mouse device-side emulator: drives the PS/2 clock, sends 3-byte standard movement packets and command responses to a PS/2 host, and receives and answers host commands. It answers the init sequence the host controller issues (reset, sample-rate setting, read ID, enable reporting). It sits between a movement/button source (test bench, or an emulated-input source) and the open-collector `ps2mclk`/`ps2mdat` pins. It is also the loopback partner for verifying the host controller.

## Interface
- `HALF`, default 2000: `clk` cycles per PS/2 clock half-period. At 50 MHz this is 40 µs, about 12.5 kHz.
- `INHIBIT`, default 4000: minimum `clk` cycles of host-held clock low that qualify a request-to-send.
- `clk`  in  1: bus clock; the only clock.
- `reset`  in  1: asynchronous, active-low reset.
- `ps2mclk`  inout  1: PS/2 clock. Open collector: driven 0 or z.
- `ps2mdat`  inout  1: PS/2 data. Open collector: driven 0 or z.
- `dx`  in  9: signed X delta for the next packet.
- `dy`  in  9: signed Y delta for the next packet.
- `btn`  in  3: {middle, right, left} buttons, active-high.
- `pkt_valid`  in  1: a movement sample is offered.
- `pkt_ready`  out  1: one-cycle pulse when `dx`/`dy`/`btn` are latched.
- `cmd`  out  8: last valid host byte received.
- `cmd_strobe`  out  1: one-cycle pulse when `cmd` updates.
- `reporting`  out  1: data reporting is enabled.
- `rate`  out  8: current sample rate.
- `busy`  out  1: a frame is in progress, or the TX queue is non-empty.

## Operation
- Input sync: two-flop synchronizers on both pins. Bus idle means both synced lines are high.
- TX queue: 4-entry byte FIFO.
  - Command responses are pushed in order.
  - A packet pushes 3 bytes, and only when the queue is empty.
  - If the FIFO is full, further pushes are dropped. This cannot occur with legal traffic.
- States: IDLE, TX, INHIBITED, RX, ACK.
- IDLE
  - Host clock low (device not driving) → INHIBITED.
  - Otherwise, queue non-empty and bus idle for ≥HALF cycles → TX.
  - Otherwise, `reporting`=1, `pkt_valid`=1 and queue empty → latch the sample, pulse `pkt_ready`, push the packet bytes.
- Packet format:
  - byte0 = {0, 0, dy[8], dx[8], 1, btn[2], btn[1], btn[0]}.
  - byte1 = dx[7:0].
  - byte2 = dy[7:0].
  - Overflow bits are always 0.
- TX frame: 11 bits = start 0, 8 data bits LSB first, odd parity, stop 1.
  - Each bit is phase A (HALF cycles, clock released, data = bit) then phase B (HALF cycles, clock driven low).
  - After bit 10 the byte is popped, both lines are released, and the block returns to IDLE.
- Host inhibit during TX: if the synced clock reads low during any phase A before bit 10, abort.
  - Release both lines; the byte stays at the queue head.
  - Go to INHIBITED; the byte is retransmitted once the bus is idle again.
- INHIBITED
  - Exit once the host clock is released.
  - If the clock was low ≥INHIBIT cycles and data is low at release → RX.
  - Otherwise → IDLE.
- RX
  - Device generates 10 clock pulses: low HALF, then high HALF.
  - Data is sampled HALF/2 cycles into each high phase, giving 8 data bits, parity, stop.
  - Then → ACK.
- ACK: device drives data low for one pulse (clock low HALF, high HALF), then releases both lines and checks the frame.
- Frame check:
  - Parity must be odd and stop must be 1.
  - On error, flush the queue and push 0xFE. `cmd_strobe` does not fire.
- Valid byte: flush any queued, unsent bytes, update `cmd`, pulse `cmd_strobe`, then decode.
  - If `rate_pending`: `rate` = byte, clear `rate_pending`, push FA.
  - FF: `reporting`=0, `rate`=100; push FA, AA, 00.
  - F6: `reporting`=0, `rate`=100; push FA.
  - F2: push FA, 00.
  - F3: set `rate_pending`; push FA.
  - F4: `reporting`=1; push FA.
  - F5: `reporting`=0; push FA.
  - Any other byte: push FE.
- Reset, including mid-frame, acts immediately:
  - Both lines are released (z).
  - State IDLE, queue empty, `rate_pending`=0.
  - `reporting`=0, `rate`=100, `cmd`=0, `cmd_strobe`=0, `pkt_ready`=0, `busy`=0.

## Timing
- One bit lasts 2·HALF cycles; a TX frame lasts 22·HALF.
- A host-to-device byte lasts 22·HALF from request release to line release (10 RX pulses plus the ACK pulse).
- The first response byte starts ≥HALF idle cycles after the ACK release.
- Consecutive queued bytes are separated by ≥HALF idle cycles.
- `pkt_ready` fires in the cycle `pkt_valid` is sampled in IDLE. The next packet is accepted only after byte2's stop bit.
- `cmd_strobe` fires one cycle after the ACK pulse ends.
- Simultaneous events:
  - A host request wins over a pending TX start.
  - A packet accept and a queue push never coincide, because packets are accepted only when the queue is empty.

## Test plan
- Host sends FF → device ACKs, then sends FA, AA, 00 with correct parity. `reporting`=0, `rate`=100.
- Host sends F3, then C8 → FA after each. `rate`=200 and `cmd`=C8 after the second strobe.
- Host sends F4, then `pkt_valid` with `dx`=−2, `dy`=0, `btn`=3'b001 → FA, then bytes 0x19, 0xFE, 0x00. `pkt_ready` is one cycle wide.
- Host sends F3 with even parity → device ACKs, then sends 0xFE. `cmd_strobe` stays low and `rate` is unchanged.
- Host pulls the clock low for 5000 cycles during bit 4 of byte1, data high at release → transmission aborts, then byte1 is resent in full. The host receives 3 intact bytes.
- `reporting`=0 with `pkt_valid` held high → `pkt_ready` never pulses and the bus stays idle. Asserting `reset` (low) mid-TX → both lines release within the same cycle and all outputs take their reset values.
